// File: rtl/alu_if.sv
// Command/result handshake bundle between the multi-cycle datapath and multicycle_alu.
interface alu_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            alu_op;
    logic [DATA_WIDTH-1:0] alu_in_1;
    logic [DATA_WIDTH-1:0] alu_in_2;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_bcond;

    modport master (
        output in_valid, alu_op, alu_in_1, alu_in_2, out_ready,
        input  in_ready, out_valid, alu_result, alu_bcond
    );

    modport slave (
        input  in_valid, alu_op, alu_in_1, alu_in_2, out_ready,
        output in_ready, out_valid, alu_result, alu_bcond
    );
endinterface

// File: rtl/multicycle_alu.sv
// Iterative ALU: single-cycle logic/arith/compare, one-bit-per-cycle shifts.
// Define MULTICYCLE_ALU_BARREL_SHIFT_EN to finish every shift in the EXEC cycle.
module multicycle_alu #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic clk,
    input  logic reset,
    alu_if.slave bus
);
    // Encodings mirror the alu_* macros of opcodes.v.
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_LLS = 4'd5;
    localparam logic [3:0] OP_LRS = 4'd6;
    localparam logic [3:0] OP_BEQ = 4'd8;
    localparam logic [3:0] OP_BNE = 4'd9;
    localparam logic [3:0] OP_BLT = 4'd10;
    localparam logic [3:0] OP_BGE = 4'd11;

`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_SHIFT = 2'd2, ST_DONE = 2'd3} state_t;

    function automatic logic [DATA_WIDTH-1:0] shift_one(input logic [DATA_WIDTH-1:0] v,
                                                        input logic left);
        return left ? {v[DATA_WIDTH-2:0], 1'b0} : {1'b0, v[DATA_WIDTH-1:1]};
    endfunction

    logic [DATA_WIDTH-1:0]  work_r;
    logic [SHAMT_WIDTH-1:0] cnt_r;
    logic [DATA_WIDTH-1:0]  step_s;
    logic                   is_shift_s;
`endif

    state_t                state_r, state_next_s;
    logic [3:0]            op_r;
    logic [DATA_WIDTH-1:0] a_r, b_r;
    logic [DATA_WIDTH-1:0] result_r;
    logic                  bcond_r;
    logic                  out_valid_r;
    logic                  in_ready_r;
    logic                  accept_s;
    logic [DATA_WIDTH-1:0] diff_s;
    logic [DATA_WIDTH-1:0] exec_result_s;
    logic                  exec_bcond_s;

    assign accept_s       = bus.in_valid && in_ready_r;
    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.alu_result = result_r;
    assign bus.alu_bcond  = bcond_r;

`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
    assign is_shift_s = (bus.alu_op == OP_LLS) || (bus.alu_op == OP_LRS);
    assign step_s     = shift_one(work_r, op_r == OP_LLS);
`endif

    // Single-cycle result for everything that runs in EXEC.
    always_comb begin
        exec_result_s = {DATA_WIDTH{1'b0}};
        exec_bcond_s  = 1'b0;
        diff_s        = a_r - b_r;
        case (op_r)
            OP_ADD: exec_result_s = a_r + b_r;
            OP_SUB: exec_result_s = diff_s;
            OP_AND: exec_result_s = a_r & b_r;
            OP_OR:  exec_result_s = a_r | b_r;
            OP_XOR: exec_result_s = a_r ^ b_r;
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
            OP_LLS: exec_result_s = a_r << b_r[SHAMT_WIDTH-1:0];
            OP_LRS: exec_result_s = a_r >> b_r[SHAMT_WIDTH-1:0];
`else
            // Only a zero shift amount reaches EXEC in the iterative build.
            OP_LLS: exec_result_s = a_r;
            OP_LRS: exec_result_s = a_r;
`endif
            OP_BEQ: begin exec_result_s = diff_s; exec_bcond_s = (a_r == b_r); end
            OP_BNE: begin exec_result_s = diff_s; exec_bcond_s = (a_r != b_r); end
            OP_BLT: begin exec_result_s = diff_s; exec_bcond_s = ($signed(a_r) <  $signed(b_r)); end
            OP_BGE: begin exec_result_s = diff_s; exec_bcond_s = ($signed(a_r) >= $signed(b_r)); end
            default: begin
                exec_result_s = {DATA_WIDTH{1'b0}};
                exec_bcond_s  = 1'b0;
            end
        endcase
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
                    state_next_s = ST_EXEC;
`else
                    if (is_shift_s && (bus.alu_in_2[SHAMT_WIDTH-1:0] != {SHAMT_WIDTH{1'b0}})) begin
                        state_next_s = ST_SHIFT;
                    end else begin
                        state_next_s = ST_EXEC;
                    end
`endif
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: state_next_s = ST_DONE;
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
            ST_SHIFT: begin
                if (cnt_r == SHAMT_WIDTH'(1)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
`endif
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register plus handshake flags, registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == ST_IDLE);
            out_valid_r <= (state_next_s == ST_DONE);
        end
    end

    // Operand latch, shifter and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r     <= 4'd0;
            a_r      <= {DATA_WIDTH{1'b0}};
            b_r      <= {DATA_WIDTH{1'b0}};
            result_r <= {DATA_WIDTH{1'b0}};
            bcond_r  <= 1'b0;
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
            work_r   <= {DATA_WIDTH{1'b0}};
            cnt_r    <= {SHAMT_WIDTH{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r   <= bus.alu_op;
                        a_r    <= bus.alu_in_1;
                        b_r    <= bus.alu_in_2;
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
                        work_r <= bus.alu_in_1;
                        cnt_r  <= bus.alu_in_2[SHAMT_WIDTH-1:0];
`endif
                    end
                end
                ST_EXEC: begin
                    result_r <= exec_result_s;
                    bcond_r  <= exec_bcond_s;
                end
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
                ST_SHIFT: begin
                    work_r <= step_s;
                    cnt_r  <= cnt_r - SHAMT_WIDTH'(1);
                    if (cnt_r == SHAMT_WIDTH'(1)) begin
                        result_r <= step_s;
                        bcond_r  <= 1'b0;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: directed commands push expectations, a monitor checks results.
module tb_multicycle_alu;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_LLS = 4'd5;
    localparam logic [3:0] OP_LRS = 4'd6;
    localparam logic [3:0] OP_BEQ = 4'd8;
    localparam logic [3:0] OP_BNE = 4'd9;
    localparam logic [3:0] OP_BLT = 4'd10;
    localparam logic [3:0] OP_BGE = 4'd11;
    localparam logic [3:0] OP_BAD = 4'd15;
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        bcond;
        int          due;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;
    bit   seen = 1'b0;
    exp_t sb_q[$];

    alu_if #(.DATA_WIDTH(32)) bus ();

    multicycle_alu #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic int shlat(input int n);
        return (BARREL || n == 0) ? 2 : n + 1;
    endfunction

    // Monitor: compare every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            checks++;
            if (bus.in_ready) begin
                errors++;
                $display("FAIL ready_valid_excl in_ready=%b out_valid=%b required in_ready=0", bus.in_ready, bus.out_valid);
            end
        end
        if (bus.out_valid && sb_q.size() > 0) begin
            if (!seen) begin
                seen = 1'b1;
                checks++;
                if (cycle != sb_q[0].due) begin
                    errors++;
                    $display("FAIL %s_latency got cycle %0d required %0d", sb_q[0].name, cycle, sb_q[0].due);
                end
            end
            checks++;
            if (bus.alu_result !== sb_q[0].res || bus.alu_bcond !== sb_q[0].bcond) begin
                errors++;
                $display("FAIL %s_result got %h/%b required %h/%b", sb_q[0].name,
                         bus.alu_result, bus.alu_bcond, sb_q[0].res, sb_q[0].bcond);
            end
            if (bus.out_ready) begin
                void'(sb_q.pop_front());
                seen = 1'b0;
            end
        end
    end

    task automatic check1(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", nm, got, req);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic bc, input int lat,
                         input bit push, input string nm);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept in_ready=0 after %0d cycles required 1", nm, n);
        end
        bus.alu_op   = op;
        bus.alu_in_1 = a;
        bus.alu_in_2 = b;
        bus.in_valid = 1'b1;
        if (push) sb_q.push_back('{res, bc, cycle + lat, nm});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required 0", nm, sb_q.size());
            sb_q.delete();
            seen = 1'b0;
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic bc, input int lat, input string nm);
        issue(op, a, b, res, bc, lat, 1'b1, nm);
        drain(nm);
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.alu_op    = 4'd0;
        bus.alu_in_1  = 32'd0;
        bus.alu_in_2  = 32'd0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check1("rst_result", bus.alu_result, 32'd0);
        check1("rst_bcond", {31'd0, bus.alu_bcond}, 32'd0);
        check1("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check1("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;

        // Abort a long shift with reset five cycles in.
        bus.out_ready = 1'b0;
        issue(OP_LLS, 32'd1, 32'd20, 32'd0, 1'b0, 0, 1'b0, "abort");
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check1("abort_result", bus.alu_result, 32'd0);
        check1("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check1("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        run(OP_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 2, "add_after_abort");

        run(OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2, "add_wrap");
        run(OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 2, "sub_neg");
        run(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 2, "and");
        run(OP_OR,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0, 2, "or");
        run(OP_LRS, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, shlat(31), "lrs31");
        run(OP_LRS, 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b0, shlat(0), "lrs0");
        run(OP_LLS, 32'd1, 32'd4, 32'h0000_0010, 1'b0, shlat(4), "lls4");
        run(OP_LLS, 32'd3, 32'd1, 32'h0000_0006, 1'b0, shlat(1), "lls1");
        run(OP_LLS, 32'h8000_0001, 32'hFFFF_FFE1, 32'h0000_0002, 1'b0, shlat(1), "lls_hi_bits");
        run(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1, 2, "blt");
        run(OP_BGE, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0, 2, "bge");
        run(OP_BEQ, 32'd9, 32'd9, 32'd0, 1'b1, 2, "beq");
        run(OP_BNE, 32'd9, 32'd9, 32'd0, 1'b0, 2, "bne");
        run(OP_BAD, 32'd5, 32'd6, 32'd0, 1'b0, 2, "undef_op");

        // Backpressure: hold the XOR result while stray commands are offered.
        bus.out_ready = 1'b0;
        issue(OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0, 2, 1'b1, "xor_stall");
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check1("stall_valid_arrives", {31'd0, bus.out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            bus.alu_op   = OP_ADD;
            bus.alu_in_1 = 32'd1;
            bus.alu_in_2 = 32'd1;
            bus.in_valid = (i % 3 == 0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check1("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check1("stall_result", bus.alu_result, 32'h0000_FF00);
        bus.out_ready = 1'b1;
        drain("xor_stall");
        check1("stall_in_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check1("stall_no_ghost", {31'd0, bus.out_valid}, 32'd0);

        run(OP_SUB, 32'd10, 32'd3, 32'd7, 1'b0, 2, "sub_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required finish before 200000", $time);
        $fatal(1);
    end
endmodule
